// File: rtl/tipi_pkg.sv
// Shared TIPI definitions: mode codes, link states and the Pi pin bundle.
package tipi_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [NIB_W-1:0] {
    MODE_RD_TD = 4'h0,
    MODE_RD_TC = 4'h1,
    MODE_WR_RD = 4'h2,
    MODE_WR_RC = 4'h3
  } tipi_mode_e;

  typedef enum logic [2:0] {
    ST_MODE  = 3'd0,
    ST_RD_HI = 3'd1,
    ST_RD_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_WR_LO = 3'd4,
    ST_ERR   = 3'd5
  } tipi_state_e;

  typedef struct packed {
    logic             clk;
    logic             nibrst;
    logic [0:NIB_W-1] nib;
  } pi_pins_t;

endpackage

// File: rtl/tipi_sync.sv
// Multi-stage synchronizer moving a bundle of asynchronous pins into clk in lockstep.
module tipi_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tipi_pi_link.sv
// Raspberry Pi nibble link: reads TD/TC out and writes RD/RC in, four bits per Pi strobe.
module tipi_pi_link
  import tipi_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] LED_HOLD    = 16'd50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_clk,
  input  logic              r_nibrst,
  input  logic [0:NIB_W-1]  r_nib_in,
  output logic [0:NIB_W-1]  r_nib_out,
  output logic              r_nib_oe,
  input  logic [0:BYTE_W-1] td,
  input  logic [0:BYTE_W-1] tc,
  output logic [0:BYTE_W-1] rd,
  output logic [0:BYTE_W-1] rc,
  output logic              rd_wr,
  output logic              rc_wr,
  output logic              act
);

  pi_pins_t pins_in;
  pi_pins_t pins_s;

  always_comb begin
    pins_in        = '0;
    pins_in.clk    = r_clk;
    pins_in.nibrst = r_nibrst;
    pins_in.nib    = r_nib_in;
  end

  tipi_sync #(
    .WIDTH  ($bits(pi_pins_t)),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pins_in),
    .q     (pins_s)
  );

  tipi_state_e       state_q, state_d;
  logic              clk_prev_q, clk_prev_d;
  logic [0:BYTE_W-1] hold_q, hold_d;
  logic [0:NIB_W-1]  stg_q, stg_d;
  logic              wr_rc_q, wr_rc_d;
  logic [0:BYTE_W-1] rd_q, rd_d;
  logic [0:BYTE_W-1] rc_q, rc_d;
  logic              rd_wr_q, rd_wr_d;
  logic              rc_wr_q, rc_wr_d;
  logic [0:NIB_W-1]  nib_out_q, nib_out_d;
  logic              nib_oe_q, nib_oe_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              act_q, act_d;
  logic              pi_edge_c;
  logic              done_c;

  assign pi_edge_c = pins_s.clk & ~clk_prev_q;

  // Protocol FSM: one action per synchronized strobe edge; nibble reset wins over everything.
  always_comb begin
    state_d    = state_q;
    clk_prev_d = pins_s.clk;
    hold_d     = hold_q;
    stg_d      = stg_q;
    wr_rc_d    = wr_rc_q;
    rd_d       = rd_q;
    rc_d       = rc_q;
    rd_wr_d    = 1'b0;
    rc_wr_d    = 1'b0;
    done_c     = 1'b0;

    if (pins_s.nibrst) begin
      state_d = ST_MODE;
    end else if (pi_edge_c) begin
      unique case (state_q)
        ST_MODE: begin
          case (pins_s.nib)
            MODE_RD_TD: begin
              hold_d  = td;
              state_d = ST_RD_HI;
            end
            MODE_RD_TC: begin
              hold_d  = tc;
              state_d = ST_RD_HI;
            end
            MODE_WR_RD: begin
              wr_rc_d = 1'b0;
              state_d = ST_WR_HI;
            end
            MODE_WR_RC: begin
              wr_rc_d = 1'b1;
              state_d = ST_WR_HI;
            end
            default: state_d = ST_ERR;
          endcase
        end
        ST_RD_HI: state_d = ST_RD_LO;
        ST_RD_LO: begin
          done_c  = 1'b1;
          state_d = ST_MODE;
        end
        ST_WR_HI: begin
          stg_d   = pins_s.nib;
          state_d = ST_WR_LO;
        end
        ST_WR_LO: begin
          if (wr_rc_q) begin
            rc_d    = {stg_q, pins_s.nib};
            rc_wr_d = 1'b1;
          end else begin
            rd_d    = {stg_q, pins_s.nib};
            rd_wr_d = 1'b1;
          end
          done_c  = 1'b1;
          state_d = ST_MODE;
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_MODE;
      endcase
    end

    nib_oe_d  = 1'b0;
    nib_out_d = '0;
    if (state_d == ST_RD_HI) begin
      nib_oe_d  = 1'b1;
      nib_out_d = hold_d[0:3];
    end else if (state_d == ST_RD_LO) begin
      nib_oe_d  = 1'b1;
      nib_out_d = hold_d[4:7];
    end

    // Activity hold counter: reload on completion, otherwise count down to zero.
    if (done_c) begin
      cnt_d = LED_HOLD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
    act_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_MODE;
      clk_prev_q <= 1'b0;
      hold_q     <= '0;
      stg_q      <= '0;
      wr_rc_q    <= 1'b0;
      rd_q       <= '0;
      rc_q       <= '0;
      rd_wr_q    <= 1'b0;
      rc_wr_q    <= 1'b0;
      nib_out_q  <= '0;
      nib_oe_q   <= 1'b0;
      cnt_q      <= '0;
      act_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_prev_q <= clk_prev_d;
      hold_q     <= hold_d;
      stg_q      <= stg_d;
      wr_rc_q    <= wr_rc_d;
      rd_q       <= rd_d;
      rc_q       <= rc_d;
      rd_wr_q    <= rd_wr_d;
      rc_wr_q    <= rc_wr_d;
      nib_out_q  <= nib_out_d;
      nib_oe_q   <= nib_oe_d;
      cnt_q      <= cnt_d;
      act_q      <= act_d;
    end
  end

  assign r_nib_out = nib_out_q;
  assign r_nib_oe  = nib_oe_q;
  assign rd        = rd_q;
  assign rc        = rc_q;
  assign rd_wr     = rd_wr_q;
  assign rc_wr     = rc_wr_q;
  assign act       = act_q;

endmodule

// File: doc/tipi_pi_link.md
TIPI_PI_LINK -- requirements
Module: tipi_pi_link

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for r_clk, r_nibrst and r_nib_in; legal values 2..3.
REQ-002 Parameter LED_HOLD, default 16'd50000: clk cycles that the activity output stays high after each completed transaction.
REQ-003 Port clk, input, 1: single block clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port r_clk, input, 1: Raspberry Pi nibble strobe; asynchronous to clk; a rising edge advances the protocol.
REQ-006 Port r_nibrst, input, 1: Raspberry Pi sequence reset; asynchronous; active high.
REQ-007 Port r_nib_in, input, [0:3]: nibble driven by the Pi; bit 0 is the MSB.
REQ-008 Port r_nib_out, output, [0:3]: nibble driven toward the Pi.
REQ-009 Port r_nib_oe, output, 1: pad output enable for r_nib.
REQ-010 Port td and tc, inputs, [0:8): TD and TC register values from the CPU-side latches.
REQ-011 Port rd and rc, outputs, [0:7]: RD and RC registers, presented to the CPU-side read mux.
REQ-012 Port rd_wr and rc_wr, outputs, 1: one-cycle pulse when rd or rc is updated.
REQ-013 Port act, output, 1: activity indicator.

Function
REQ-014 r_clk, r_nibrst and r_nib_in SHALL pass through SYNC_STAGES flops in lockstep; the rising edge of r_clk is detected from the last stage and its previous value.
REQ-015 The state machine SHALL take one action per detected edge, in the cycle after detection; latency from the r_clk pin to the action is SYNC_STAGES+1 clk cycles.
REQ-016 States:
- MODE
- RD_HI, RD_LO (read, block drives the bus)
- WR_HI, WR_LO (write, Pi drives the bus)
- ERR
REQ-017 In MODE, an edge SHALL decode the synchronized nibble as follows:
- 4'h0: read TD. Snapshot td into an 8-bit hold register; go to RD_HI.
- 4'h1: read TC. Snapshot tc into the hold register; go to RD_HI.
- 4'h2: write RD; go to WR_HI.
- 4'h3: write RC; go to WR_HI.
- Any other value: go to ERR.
REQ-018 In RD_HI, r_nib_out SHALL equal hold[0:3] and r_nib_oe SHALL be 1; an edge moves to RD_LO.
REQ-019 In RD_LO, r_nib_out SHALL equal hold[4:7] and r_nib_oe SHALL be 1; an edge returns to MODE.
REQ-020 In every state other than RD_HI and RD_LO, r_nib_oe SHALL be 0 and r_nib_out SHALL be 4'h0.
REQ-021 In WR_HI, an edge SHALL store the nibble into a staging register as the high half; go to WR_LO.
REQ-022 In WR_LO, an edge SHALL complete the write and return to MODE:
- The target (rd or rc) is written atomically with {staged, nibble}.
- The matching rd_wr or rc_wr pulses for exactly one cycle.
- A partial write SHALL never be visible on rd or rc.
REQ-023 ERR SHALL ignore all edges; only a synchronized r_nibrst high SHALL exit it.
REQ-024 A synchronized r_nibrst high SHALL force MODE from any state on the next cycle:
- It overrides a coincident r_clk edge.
- It aborts a write with rd/rc unchanged and no strobe.
- rd, rc and the hold register are retained.
REQ-025 Changes on td or tc after the snapshot SHALL NOT alter the bytes being read out.
REQ-026 Completion of a transaction is a write's final edge or RD_LO's edge. Each completion SHALL:
- Load a 16-bit counter with LED_HOLD.
- Set act=1 while the counter is nonzero; the counter decrements to 0 and saturates there.
- Restart the counter to LED_HOLD if a new completion occurs while it is counting.

Reset
REQ-027 When rst_n=0 at a clk edge, the block SHALL reset to:
- State MODE.
- rd=8'h00, rc=8'h00, hold=8'h00, staging=4'h0.
- rd_wr=0, rc_wr=0, r_nib_oe=0, r_nib_out=4'h0.
- Counter 0, act=0.
- All synchronizer flops 0.
REQ-028 A reset asserted mid-transaction SHALL abandon it without a strobe; the first edge after reset SHALL be decoded as a mode nibble.

Structure
REQ-029 The mode codes 4'h0–4'h3 and the state encodings SHALL live in a shared package, tipi_pkg, which is also used by the Pi-side test models.
REQ-030 The synchronizer SHALL be one sub-module, tipi_sync, parameterized by width and stages; it is instantiated once for the 6-bit bundle {r_clk, r_nibrst, r_nib_in}.
REQ-031 The Pi SHALL hold r_nib_in stable for at least SYNC_STAGES+2 clk cycles around each r_clk rising edge; the bench SHALL respect this constraint.

Verification
REQ-032 Write RD: nibbles 2, A, 5 on three r_clk edges -> rd=8'hA5 and a single rd_wr pulse exactly SYNC_STAGES+1 cycles after the third pin edge; rc unchanged.
REQ-033 Read TC with tc=8'h3C: mode 1 -> r_nib_oe=1 and r_nib_out=4'h3; after the next edge r_nib_out=4'hC; after the next edge r_nib_oe=0. Changing tc to 8'hFF after the mode edge still yields 3 then C.
REQ-034 Mode nibble 4'h7 -> ERR:
- Nibbles 3, 1, 2 that follow have no effect, and rc stays 8'h00.
- After an r_nibrst pulse, sequence 3, 1, 2 -> rc=8'h12.
REQ-035 Abort: write RC with nibbles 3, F, then r_nibrst high coincident with an r_clk edge -> rc unchanged, no rc_wr, state MODE.
REQ-036 Reset mid-read: rst_n=0 during RD_LO -> r_nib_oe=0 on the next cycle, then a normal read of TD with td=8'h81 returns 8 then 1.
REQ-037 Activity with LED_HOLD=4: one completed write -> act high for exactly 4 cycles; a second completion at count 2 restarts the hold to 4.
